// File: rtl/pc_stack_sequencer.sv
// Program-counter unit: increment, branch, jump, call/return through a
// return-address stack, and single-level context exchange with saved EPC.
module pc_stack_sequencer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned RESET_VEC   = 256,
    parameter int unsigned CTX_VEC     = 1083,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned SP_W        = 3
) (
    input  logic              clock,
    input  logic              resetCPU,
    input  logic              HLT,
    input  logic [ADDR_W-1:0] address,
    input  logic              zero,
    input  logic              negative,
    input  logic              bzero,
    input  logic              bnegative,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic              jump_context_exchange,
    input  logic              ctx_return,
    output logic [ADDR_W-1:0] programCounter,
    output logic [ADDR_W-1:0] epc,
    output logic              in_context,
    output logic [SP_W:0]     sp,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam logic [SP_W:0]     SP_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] PC_CTX  = ADDR_W'(CTX_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              ctx_q, ctx_d;
    logic [SP_W:0]     sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] branch_add;
    logic              branch_taken;
    logic              push_en;
    logic [SP_W-1:0]   push_idx;
    logic [SP_W-1:0]   pop_idx;

    assign pc_inc       = pc_q + ADDR_W'(1);
    assign branch_add   = pc_inc + address;
    assign branch_taken = (bzero & zero) | (bnegative & negative);
    assign push_idx     = sp_q[SP_W-1:0];
    assign pop_idx      = SP_W'(sp_q - (SP_W+1)'(1));

    // Next-state decode in priority order; ignored context requests fall through.
    always_comb begin
        pc_d    = pc_inc;
        epc_d   = epc_q;
        ctx_d   = ctx_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (HLT) begin
            pc_d = pc_q;
        end else if (jump_context_exchange && !ctx_q) begin
            epc_d = pc_inc;
            ctx_d = 1'b1;
            pc_d  = PC_CTX;
        end else if (ctx_return && ctx_q) begin
            pc_d  = epc_q;
            ctx_d = 1'b0;
        end else if (ret) begin
            if (sp_q == '0) begin
                unf_d = 1'b1;
            end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - (SP_W+1)'(1);
            end
        end else if (call) begin
            pc_d = address;
            if (sp_q == SP_FULL) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + (SP_W+1)'(1);
            end
        end else if (jump) begin
            pc_d = address;
        end else if (branch_taken) begin
            pc_d = branch_add;
        end
    end

    always_ff @(posedge clock) begin
        if (resetCPU) begin
            pc_q  <= PC_RST;
            epc_q <= '0;
            ctx_q <= 1'b0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ctx_q <= ctx_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage is not reset; a push is suppressed when reset wins the edge.
    always_ff @(posedge clock) begin
        if (!resetCPU && push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign programCounter  = pc_q;
    assign epc             = epc_q;
    assign in_context      = ctx_q;
    assign sp              = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed vector bench for pc_stack_sequencer: one table of per-cycle
// stimulus/expectations plus a hand-written stack fill/drain sequence.
module tb_pc_stack_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned SP_W   = 3;

    localparam logic [10:0] RST  = 11'd1;
    localparam logic [10:0] HL   = 11'd2;
    localparam logic [10:0] JCE  = 11'd4;
    localparam logic [10:0] CRET = 11'd8;
    localparam logic [10:0] RET  = 11'd16;
    localparam logic [10:0] CALL = 11'd32;
    localparam logic [10:0] JMP  = 11'd64;
    localparam logic [10:0] BZ   = 11'd128;
    localparam logic [10:0] BN   = 11'd256;
    localparam logic [10:0] ZF   = 11'd512;
    localparam logic [10:0] NF   = 11'd1024;

    typedef struct {
        logic [10:0]       ctrl;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] epc;
        logic              ctx;
        logic [SP_W:0]     sp;
        logic              ovf;
        logic              unf;
    } vec_t;

    logic              clock = 1'b0;
    logic              resetCPU, HLT, zero, negative, bzero, bnegative;
    logic              jump, call, ret, jump_context_exchange, ctx_return;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] programCounter, epc;
    logic              in_context, stack_overflow, stack_underflow;
    logic [SP_W:0]     sp;

    int tests  = 0;
    int errors = 0;

    pc_stack_sequencer dut (
        .clock                 (clock),
        .resetCPU              (resetCPU),
        .HLT                   (HLT),
        .address               (address),
        .zero                  (zero),
        .negative              (negative),
        .bzero                 (bzero),
        .bnegative             (bnegative),
        .jump                  (jump),
        .call                  (call),
        .ret                   (ret),
        .jump_context_exchange (jump_context_exchange),
        .ctx_return            (ctx_return),
        .programCounter        (programCounter),
        .epc                   (epc),
        .in_context            (in_context),
        .sp                    (sp),
        .stack_overflow        (stack_overflow),
        .stack_underflow       (stack_underflow)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(input logic [10:0] c, input int a, input int p, input int e,
                               input logic cx, input int s, input logic o, input logic u);
        vec_t r;
        r.ctrl = c;
        r.addr = ADDR_W'(a);
        r.pc   = ADDR_W'(p);
        r.epc  = ADDR_W'(e);
        r.ctx  = cx;
        r.sp   = (SP_W+1)'(s);
        r.ovf  = o;
        r.unf  = u;
        return r;
    endfunction

    // Drive one cycle of stimulus, clock it, then check all outputs.
    task automatic apply(input vec_t t, input string name);
        resetCPU              = t.ctrl[0];
        HLT                   = t.ctrl[1];
        jump_context_exchange = t.ctrl[2];
        ctx_return            = t.ctrl[3];
        ret                   = t.ctrl[4];
        call                  = t.ctrl[5];
        jump                  = t.ctrl[6];
        bzero                 = t.ctrl[7];
        bnegative             = t.ctrl[8];
        zero                  = t.ctrl[9];
        negative              = t.ctrl[10];
        address               = t.addr;
        @(posedge clock);
        #1;
        tests++;
        if (programCounter !== t.pc || epc !== t.epc || in_context !== t.ctx ||
            sp !== t.sp || stack_overflow !== t.ovf || stack_underflow !== t.unf) begin
            errors++;
            $display("FAIL %s: got pc=%0d epc=%0d ctx=%b sp=%0d ovf=%b unf=%b, want pc=%0d epc=%0d ctx=%b sp=%0d ovf=%b unf=%b",
                     name, programCounter, epc, in_context, sp, stack_overflow, stack_underflow,
                     t.pc, t.epc, t.ctx, t.sp, t.ovf, t.unf);
        end
    endtask

    vec_t tbl[$];

    initial begin
        resetCPU = 1'b1; HLT = 1'b0; zero = 1'b0; negative = 1'b0;
        bzero = 1'b0; bnegative = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        jump_context_exchange = 1'b0; ctx_return = 1'b0; address = '0;

        //           ctrl                addr   pc    epc  ctx sp ovf unf
        tbl.push_back(v(RST,              0,    256,  0,   0, 0, 0, 0));
        tbl.push_back(v(0,                0,    257,  0,   0, 0, 0, 0));
        tbl.push_back(v(0,                0,    258,  0,   0, 0, 0, 0));
        tbl.push_back(v(0,                0,    259,  0,   0, 0, 0, 0));
        tbl.push_back(v(JMP,              300,  300,  0,   0, 0, 0, 0));
        tbl.push_back(v(BZ|ZF,            5,    306,  0,   0, 0, 0, 0));
        tbl.push_back(v(JMP,              300,  300,  0,   0, 0, 0, 0));
        tbl.push_back(v(BZ,               5,    301,  0,   0, 0, 0, 0));
        tbl.push_back(v(JMP|BZ|ZF,        40,   40,   0,   0, 0, 0, 0));
        tbl.push_back(v(BN|NF,            4095, 40,   0,   0, 0, 0, 0));
        tbl.push_back(v(JMP,              100,  100,  0,   0, 0, 0, 0));
        tbl.push_back(v(CALL,             500,  500,  0,   0, 1, 0, 0));
        tbl.push_back(v(CALL,             700,  700,  0,   0, 2, 0, 0));
        tbl.push_back(v(RET,              0,    501,  0,   0, 1, 0, 0));
        tbl.push_back(v(RET,              0,    101,  0,   0, 0, 0, 0));
        tbl.push_back(v(RET,              0,    102,  0,   0, 0, 0, 1));
        tbl.push_back(v(JMP,              400,  400,  0,   0, 0, 0, 1));
        tbl.push_back(v(JCE,              0,    1083, 401, 1, 0, 0, 1));
        tbl.push_back(v(JCE,              0,    1084, 401, 1, 0, 0, 1));
        tbl.push_back(v(CRET,             0,    401,  401, 0, 0, 0, 1));
        tbl.push_back(v(CRET|JMP,         50,   50,   401, 0, 0, 0, 1));
        tbl.push_back(v(JCE|CALL,         600,  1083, 51,  1, 0, 0, 1));
        tbl.push_back(v(JCE|CALL,         600,  600,  51,  1, 1, 0, 1));
        tbl.push_back(v(CRET|RET,         0,    51,   51,  0, 1, 0, 1));
        tbl.push_back(v(RET,              0,    1084, 51,  0, 0, 0, 1));
        tbl.push_back(v(HL|CALL,          10,   1084, 51,  0, 0, 0, 1));
        tbl.push_back(v(HL|CALL,          10,   1084, 51,  0, 0, 0, 1));
        tbl.push_back(v(HL|CALL|JCE,      10,   1084, 51,  0, 0, 0, 1));
        tbl.push_back(v(JMP,              4095, 4095, 51,  0, 0, 0, 1));
        tbl.push_back(v(0,                0,    0,    51,  0, 0, 0, 1));
        tbl.push_back(v(RST|HL|CALL,      5,    256,  0,   0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill the stack: pushes 257, 17, 33, ..., 113 (call i from PC 16*i).
        for (int i = 0; i < 8; i++) begin
            apply(v(CALL, 16 * (i + 1), 16 * (i + 1), 0, 0, i + 1, 0, 0),
                  $sformatf("fill%0d", i));
        end
        apply(v(CALL, 900, 900, 0, 0, 8, 1, 0), "overflow_call");
        for (int k = 7; k >= 0; k--) begin
            apply(v(RET, 0, (k == 0) ? 257 : 16 * k + 1, 0, 0, k, 1, 0),
                  $sformatf("drain%0d", k));
        end
        apply(v(RET, 0, 258, 0, 0, 0, 1, 1), "underflow_ret");
        apply(v(CALL, 77, 77, 0, 0, 1, 1, 1), "call_after_underflow");
        apply(v(RST|CALL, 33, 256, 0, 0, 0, 0, 0), "reset_with_call");
        apply(v(0, 0, 257, 0, 0, 0, 0, 0), "idle_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
